// File: rtl/stream_deserializer_flushable.sv
// Stream deserializer with early close, flush and synchronous clear.
//
// Collects Ratio input beats of type T into one output word. A beat with
// last_i set closes the word early, and slots that were never written read
// as '0. flush_i throws away a partially assembled word. clr_i returns
// every register to its reset value.
//
// Ports
//   clk_i    : clock; all state changes on the rising edge
//   rst_ni   : asynchronous reset, active low
//   clr_i    : synchronous clear of all state (highest priority)
//   flush_i  : synchronous discard of the partial word; the beat offered
//              in the same cycle is dropped
//   valid_i  : input beat valid
//   ready_o  : input beat accepted when high together with valid_i
//   data_i   : input beat
//   last_i   : this beat closes the current word
//   valid_o  : output word valid
//   ready_i  : downstream accepts the word
//   data_o   : output word; slot k holds the k-th accepted beat
//   cnt_o    : number of valid slots (1..Ratio) while valid_o is high

module stream_deserializer_flushable #(
    parameter type         T     = logic,
    parameter int unsigned Ratio = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       clr_i,
    input  logic                       flush_i,
    input  logic                       valid_i,
    output logic                       ready_o,
    input  T                           data_i,
    input  logic                       last_i,
    output logic                       valid_o,
    input  logic                       ready_i,
    output T                           data_o [Ratio],
    output logic [$clog2(Ratio+1)-1:0] cnt_o
);

    localparam int unsigned CntW = $clog2(Ratio + 1);
    localparam int unsigned IdxW = (Ratio > 1) ? $clog2(Ratio) : 1;

    if (Ratio == 0 || Ratio > 16) begin : gen_ratio_check
        $error("stream_deserializer_flushable: Ratio must be in 1..16");
    end

    // One buffer serves both roles: the word being assembled while full_q
    // is low, and the word on offer while full_q is high. A new word can
    // only start filling in the same cycle the old one is handed off, so
    // the two never coexist.
    T                  buf_q [Ratio];
    T                  buf_d [Ratio];
    logic [IdxW-1:0]   cnt_q, cnt_d;
    logic [CntW-1:0]   out_cnt_q, out_cnt_d;
    logic              full_q, full_d;

    logic accept;
    logic handshake;
    logic complete;

    assign ready_o   = !full_q || ready_i;
    assign valid_o   = full_q;
    assign cnt_o     = out_cnt_q;
    assign data_o    = buf_q;

    assign handshake = full_q && ready_i;
    assign accept    = valid_i && ready_o && !flush_i;
    assign complete  = (cnt_q == IdxW'(Ratio - 1)) || last_i;

    always_comb begin
        buf_d     = buf_q;
        cnt_d     = cnt_q;
        out_cnt_d = out_cnt_q;
        full_d    = full_q;

        if (handshake) begin
            full_d    = 1'b0;
            out_cnt_d = '0;
            for (int i = 0; i < int'(Ratio); i++) begin
                buf_d[i] = '0;
            end
        end

        // While full_q is set the partial word is empty, so a flush only
        // has something to discard when no word is pending.
        if (flush_i && !full_q) begin
            cnt_d = '0;
            for (int i = 0; i < int'(Ratio); i++) begin
                buf_d[i] = '0;
            end
        end

        // cnt_q is always 0 while full_q is set, so a beat accepted during
        // a handshake lands in slot 0 of the freshly zeroed buffer.
        if (accept) begin
            buf_d[cnt_q] = data_i;
            if (complete) begin
                full_d    = 1'b1;
                out_cnt_d = CntW'(cnt_q) + CntW'(1);
                cnt_d     = '0;
            end else begin
                cnt_d     = cnt_q + IdxW'(1);
            end
        end

        if (clr_i) begin
            cnt_d     = '0;
            out_cnt_d = '0;
            full_d    = 1'b0;
            for (int i = 0; i < int'(Ratio); i++) begin
                buf_d[i] = '0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q     <= '0;
            out_cnt_q <= '0;
            full_q    <= 1'b0;
            for (int i = 0; i < int'(Ratio); i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            cnt_q     <= cnt_d;
            out_cnt_q <= out_cnt_d;
            full_q    <= full_d;
            buf_q     <= buf_d;
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk_i) begin
        if (rst_ni && flush_i && valid_i) begin
            $warning("stream_deserializer_flushable: beat dropped by flush_i");
        end
    end
`endif

endmodule

// File: tb/tb_stream_deserializer_flushable.sv
// Randomized and directed bench for stream_deserializer_flushable
// (T = 8-bit beat, Ratio = 4) against a queue-based word model.

module tb_stream_deserializer_flushable;

    localparam int unsigned Ratio = 4;

    logic       clk_i;
    logic       rst_ni;
    logic       clr_i;
    logic       flush_i;
    logic       valid_i;
    logic       ready_o;
    logic [7:0] data_i;
    logic       last_i;
    logic       valid_o;
    logic       ready_i;
    logic [7:0] data_o [Ratio];
    logic [2:0] cnt_o;

    int checks;
    int errors;

    // Reference model: beats of the word under construction, plus the
    // word waiting at the output (slot 0 in the top byte).
    logic [7:0]  m_part [$];
    bit          m_pend;
    logic [31:0] m_word;
    int          m_cnt;

    stream_deserializer_flushable #(
        .T     (logic [7:0]),
        .Ratio (Ratio)
    ) dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clr_i   (clr_i),
        .flush_i (flush_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .data_i  (data_i),
        .last_i  (last_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .data_o  (data_o),
        .cnt_o   (cnt_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] dut_word();
        return {data_o[0], data_o[1], data_o[2], data_o[3]};
    endfunction

    function automatic void model_reset();
        m_part.delete();
        m_pend = 1'b0;
        m_word = '0;
        m_cnt  = 0;
    endfunction

    function automatic void model_clock(bit v, logic [7:0] d, bit l, bit r, bit f, bit c);
        bit hs;
        bit acc;
        if (c) begin
            model_reset();
            return;
        end
        hs  = m_pend && r;
        acc = v && (!m_pend || r) && !f;
        if (hs) m_pend = 1'b0;
        if (f) m_part.delete();
        if (acc) begin
            m_part.push_back(d);
            if (m_part.size() == Ratio || l) begin
                m_word = '0;
                for (int i = 0; i < m_part.size(); i++) begin
                    m_word[31 - 8 * i -: 8] = m_part[i];
                end
                m_cnt  = m_part.size();
                m_pend = 1'b1;
                m_part.delete();
            end
        end
    endfunction

    // Drive one cycle of inputs, check ready_o, clock, then check outputs.
    task automatic step(input bit v, input logic [7:0] d, input bit l, input bit r,
                        input bit f, input bit c);
        valid_i = v;
        data_i  = d;
        last_i  = l;
        ready_i = r;
        flush_i = f;
        clr_i   = c;
        #1;
        check_eq("ready_o", {31'd0, ready_o}, {31'd0, !m_pend || r});
        @(posedge clk_i);
        model_clock(v, d, l, r, f, c);
        #1;
        check_eq("valid_o", {31'd0, valid_o}, {31'd0, m_pend});
        if (m_pend) begin
            check_eq("cnt_o", {29'd0, cnt_o}, m_cnt);
            check_eq("data_o", dut_word(), m_word);
        end
    endtask

    task automatic idle(input bit r);
        step(1'b0, 8'h00, 1'b0, r, 1'b0, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_valid"}, {31'd0, valid_o}, 32'd0);
        check_eq({tag, "_ready"}, {31'd0, ready_o}, 32'd1);
        check_eq({tag, "_cnt"}, {29'd0, cnt_o}, 32'd0);
        check_eq({tag, "_data"}, dut_word(), 32'd0);
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rst_ni  = 1'b0;
        clr_i   = 1'b0;
        flush_i = 1'b0;
        valid_i = 1'b0;
        data_i  = '0;
        last_i  = 1'b0;
        ready_i = 1'b0;
        model_reset();

        #12;
        check_reset_outputs("reset");
        @(posedge clk_i);
        #1 rst_ni = 1'b1;

        // Full word with ready held high.
        step(1, 8'h11, 0, 1, 0, 0);
        step(1, 8'h22, 0, 1, 0, 0);
        step(1, 8'h33, 0, 1, 0, 0);
        check_eq("no_early_valid", {31'd0, valid_o}, 32'd0);
        step(1, 8'h44, 0, 1, 0, 0);
        check_eq("full_word", dut_word(), 32'h11223344);
        check_eq("full_cnt", {29'd0, cnt_o}, 32'd4);
        idle(1);

        // Early close by last_i.
        step(1, 8'h0A, 0, 1, 0, 0);
        step(1, 8'h0B, 1, 1, 0, 0);
        check_eq("early_word", dut_word(), 32'h0A0B0000);
        check_eq("early_cnt", {29'd0, cnt_o}, 32'd2);
        idle(1);

        // Backpressure: word held for 5 cycles, offered beats refused.
        step(1, 8'hA1, 0, 0, 0, 0);
        step(1, 8'hA2, 0, 0, 0, 0);
        step(1, 8'hA3, 0, 0, 0, 0);
        step(1, 8'hA4, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(1, 8'hEE, 0, 0, 0, 0);
        check_eq("bp_hold", dut_word(), 32'hA1A2A3A4);
        step(1, 8'h55, 0, 1, 0, 0);
        check_eq("bp_released", {31'd0, valid_o}, 32'd0);
        step(1, 8'h66, 0, 1, 0, 0);
        step(1, 8'h77, 0, 1, 0, 0);
        step(1, 8'h88, 0, 1, 0, 0);
        check_eq("bp_slot0", dut_word(), 32'h55667788);
        idle(1);

        // Flush of a partial word, then a clean word.
        step(1, 8'h01, 0, 1, 0, 0);
        step(1, 8'h02, 0, 1, 0, 0);
        step(0, 8'h00, 0, 1, 1, 0);
        step(1, 8'h03, 0, 1, 0, 0);
        step(1, 8'h04, 0, 1, 0, 0);
        step(1, 8'h05, 0, 1, 0, 0);
        step(1, 8'h06, 0, 0, 0, 0);
        check_eq("flush_word", dut_word(), 32'h03040506);
        // Flush while a word is pending keeps it.
        step(1, 8'h99, 0, 0, 1, 0);
        check_eq("flush_keep", dut_word(), 32'h03040506);
        idle(1);

        // Clear beats flush while a word is pending.
        step(1, 8'hC1, 0, 1, 0, 0);
        step(1, 8'hC2, 1, 0, 0, 0);
        check_eq("clr_pre", {31'd0, valid_o}, 32'd1);
        step(0, 8'h00, 0, 0, 1, 1);
        check_eq("clr_valid", {31'd0, valid_o}, 32'd0);
        idle(1);

        // Asynchronous reset between edges after three beats.
        step(1, 8'h31, 0, 1, 0, 0);
        step(1, 8'h32, 0, 1, 0, 0);
        step(1, 8'h33, 0, 1, 0, 0);
        valid_i = 1'b0;
        #2 rst_ni = 1'b0;
        #1;
        model_reset();
        check_reset_outputs("async");
        @(posedge clk_i);
        #1 rst_ni = 1'b1;
        step(1, 8'h41, 0, 1, 0, 0);
        step(1, 8'h42, 0, 1, 0, 0);
        step(1, 8'h43, 0, 1, 0, 0);
        step(1, 8'h44, 0, 1, 0, 0);
        check_eq("async_word", dut_word(), 32'h41424344);
        check_eq("async_cnt", {29'd0, cnt_o}, 32'd4);

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            step($urandom_range(0, 9) < 7, 8'($urandom), $urandom_range(0, 9) == 0,
                 $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0,
                 $urandom_range(0, 49) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
